vga_timing_gen: RTL and testbench

Video timing generator for the 65 MHz pixel domain. It consumes the 65 MHz PLL output clock and the PLL `locked` flag, and holds off until lock is stable. It then produces 1024x768@60 raster timing (hsync, vsync, data-enable, pixel coordinates), a frame-start strobe and a per-line prefetch request for the frame-buffer reader. Any loss of lock returns it to a blanked idle state.

---
 rtl/vga_timing_gen_pkg.sv | 34 +++
 rtl/vga_timing_gen_if.sv | 22 ++
 rtl/vga_timing_gen_sync_2ff.sv | 21 ++
 rtl/vga_timing_gen.sv | 161 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared constants, derived totals and FSM state type for the 1024x768@60 timing generator.
package vga_timing_pkg;

    localparam int unsigned DEF_H_ACTIVE  = 1024;
    localparam int unsigned DEF_H_FP      = 24;
    localparam int unsigned DEF_H_SYNC    = 136;
    localparam int unsigned DEF_H_BP      = 160;
    localparam int unsigned DEF_V_ACTIVE  = 768;
    localparam int unsigned DEF_V_FP      = 3;
    localparam int unsigned DEF_V_SYNC    = 6;
    localparam int unsigned DEF_V_BP      = 29;
    localparam int unsigned DEF_LOCK_WAIT = 1024;
    localparam int unsigned DEF_PREFETCH  = 8;

    localparam int unsigned H_CNT_W = 11;
    localparam int unsigned V_CNT_W = 10;

    function automatic int unsigned h_total(int unsigned active, int unsigned fp,
                                            int unsigned sync, int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned v_total(int unsigned active, int unsigned fp,
                                            int unsigned sync, int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    typedef enum logic [1:0] {
        WAIT_LOCK,
        SETTLE,
        RUN
    } state_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the generator to the video pipeline and frame-buffer reader.
interface vga_timing_gen_if;

    logic        hsync;
    logic        vsync;
    logic        de;
    logic [10:0] x;
    logic [9:0]  y;
    logic        frame_start;
    logic        line_req;
    logic [9:0]  line_req_y;
    logic        running;

    modport master (
        output hsync, vsync, de, x, y, frame_start, line_req, line_req_y, running
    );

    modport slave (
        input hsync, vsync, de, x, y, frame_start, line_req, line_req_y, running
    );

endinterface

// File: rtl/vga_timing_gen_sync_2ff.sv
// Two-flop single-bit synchronizer, asynchronously reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: waits for a stable PLL lock, then emits sync/DE/coordinates,
// a frame-start strobe and a per-line prefetch request. Lock loss returns to blanked idle.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
    parameter int unsigned H_FP      = DEF_H_FP,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BP      = DEF_H_BP,
    parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
    parameter int unsigned V_FP      = DEF_V_FP,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BP      = DEF_V_BP,
    parameter logic        HS_POL    = 1'b0,
    parameter logic        VS_POL    = 1'b0,
    parameter int unsigned LOCK_WAIT = DEF_LOCK_WAIT,
    parameter int unsigned PREFETCH  = DEF_PREFETCH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             locked,
    vga_timing_gen_if.master vid
);

    localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned CW      = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

    if (H_TOTAL > 2048) begin : g_chk_htotal
        $error("vga_timing_gen: H_TOTAL exceeds 2048");
    end
    if (V_TOTAL > 1024) begin : g_chk_vtotal
        $error("vga_timing_gen: V_TOTAL exceeds 1024");
    end
    if (PREFETCH < 1 || PREFETCH > H_FP + H_SYNC + H_BP) begin : g_chk_prefetch
        $error("vga_timing_gen: PREFETCH out of range");
    end
    if (LOCK_WAIT < 1) begin : g_chk_lockwait
        $error("vga_timing_gen: LOCK_WAIT must be at least 1");
    end

    // Sync-window ends may equal the total (2048/1024), so they carry one extra bit.
    localparam logic [H_CNT_W-1:0] H_LAST   = H_CNT_W'(H_TOTAL - 1);
    localparam logic [H_CNT_W-1:0] H_ACT    = H_CNT_W'(H_ACTIVE);
    localparam logic [H_CNT_W-1:0] HS_START = H_CNT_W'(H_ACTIVE + H_FP);
    localparam logic [H_CNT_W:0]   HS_END   = (H_CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [H_CNT_W-1:0] REQ_H    = H_CNT_W'(H_TOTAL - PREFETCH);
    localparam logic [V_CNT_W-1:0] V_LAST   = V_CNT_W'(V_TOTAL - 1);
    localparam logic [V_CNT_W-1:0] V_ACT    = V_CNT_W'(V_ACTIVE);
    localparam logic [V_CNT_W-1:0] VS_START = V_CNT_W'(V_ACTIVE + V_FP);
    localparam logic [V_CNT_W:0]   VS_END   = (V_CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0]      CNT_LAST = CW'(LOCK_WAIT - 1);

    logic               lk_s;
    state_t             state, state_nx;
    logic [CW-1:0]      cnt, cnt_nx;
    logic [H_CNT_W-1:0] h;
    logic [V_CNT_W-1:0] v, nv;
    logic               run_go;

    logic               hsync_q, vsync_q, de_q, frame_start_q, line_req_q, running_q;
    logic [H_CNT_W-1:0] x_q;
    logic [V_CNT_W-1:0] y_q, line_req_y_q;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (locked),
        .q   (lk_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = '0;
        unique case (state)
            WAIT_LOCK: if (lk_s) state_nx = SETTLE;
            SETTLE: begin
                if (!lk_s)                 state_nx = WAIT_LOCK;
                else if (cnt == CNT_LAST)  state_nx = RUN;
                else                       cnt_nx   = cnt + 1'b1;
            end
            RUN:       if (!lk_s) state_nx = WAIT_LOCK;
            default:   state_nx = WAIT_LOCK;
        endcase
    end

    // Counters clear on the same edge the FSM leaves RUN.
    assign run_go = (state == RUN) && lk_s;
    assign nv     = (v == V_LAST) ? '0 : v + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else if (!run_go) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= nv;
        end else begin
            h <= h + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            frame_start_q <= 1'b0;
            line_req_q    <= 1'b0;
            line_req_y_q  <= '0;
            running_q     <= 1'b0;
        end else begin
            running_q <= (state_nx == RUN);
            if (state != RUN) begin
                hsync_q       <= ~HS_POL;
                vsync_q       <= ~VS_POL;
                de_q          <= 1'b0;
                x_q           <= '0;
                y_q           <= '0;
                frame_start_q <= 1'b0;
                line_req_q    <= 1'b0;
                line_req_y_q  <= '0;
            end else begin
                hsync_q       <= ((h >= HS_START) && ({1'b0, h} < HS_END)) ? HS_POL : ~HS_POL;
                vsync_q       <= ((v >= VS_START) && ({1'b0, v} < VS_END)) ? VS_POL : ~VS_POL;
                de_q          <= (h < H_ACT) && (v < V_ACT);
                x_q           <= h;
                y_q           <= v;
                frame_start_q <= (h == '0) && (v == '0);
                line_req_q    <= (h == REQ_H) && (nv < V_ACT);
                if ((h == REQ_H) && (nv < V_ACT)) line_req_y_q <= nv;
            end
        end
    end

    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
    assign vid.de          = de_q;
    assign vid.x           = x_q;
    assign vid.y           = y_q;
    assign vid.frame_start = frame_start_q;
    assign vid.line_req    = line_req_q;
    assign vid.line_req_y  = line_req_y_q;
    assign vid.running     = running_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen with a reduced raster; expected values come from a position-based raster model.
module tb_vga_timing_gen;

    localparam int unsigned HA = 32, HF = 4, HS = 8, HB = 6;
    localparam int unsigned VA = 12, VF = 2, VS = 3, VB = 2;
    localparam int unsigned LW = 40, PF = 5;
    localparam int unsigned HT = HA + HF + HS + HB;
    localparam int unsigned VT = VA + VF + VS + VB;
    localparam int unsigned FR = HT * VT;
    localparam int unsigned RUN_LAT = 2 + LW + 1;

    // {hsync, vsync, de, x, y, frame_start, line_req, line_req_y, running} when blanked/idle
    localparam logic [36:0] IDLE = {1'b1, 1'b1, 1'b0, 11'd0, 10'd0, 1'b0, 1'b0, 10'd0, 1'b0};

    logic clk = 1'b0;
    logic rst;
    logic locked;

    vga_timing_gen_if vid ();

    vga_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .HS_POL (1'b0), .VS_POL (1'b0),
        .LOCK_WAIT (LW), .PREFETCH (PF)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .locked (locked),
        .vid    (vid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int unsigned pix = 0;
    int unsigned cyc = 0;
    int unsigned de_cnt, hs_cnt, vs_cnt, lr_cnt, fs_cnt, last_fs;
    int unsigned fs_gaps[$];

    typedef struct {
        logic hs, vs, de, fs, lr;
        int unsigned x, y, lry;
    } exp_t;

    function automatic exp_t model(int unsigned p);
        exp_t e;
        int unsigned h, v, nv;
        h = p % HT;
        v = (p / HT) % VT;
        nv = (v + 1) % VT;
        e.de  = (h < HA) && (v < VA);
        e.hs  = !((h >= HA + HF) && (h < HA + HF + HS));
        e.vs  = !((v >= VA + VF) && (v < VA + VF + VS));
        e.fs  = (p % FR) == 0;
        e.lr  = (h == HT - PF) && (nv < VA);
        e.x   = h;
        e.y   = v;
        e.lry = nv;
        return e;
    endfunction

    function automatic logic [36:0] outs();
        return {vid.hsync, vid.vsync, vid.de, vid.x, vid.y, vid.frame_start,
                vid.line_req, vid.line_req_y, vid.running};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Compares each cycle against the model at raster position pix, then advances one clock.
    task automatic run_raster(int unsigned n, string tag);
        exp_t e;
        logic bad;
        for (int unsigned i = 0; i < n; i++) begin
            e = model(pix);
            bad = (vid.hsync !== e.hs) || (vid.vsync !== e.vs) || (vid.de !== e.de) ||
                  (vid.frame_start !== e.fs) || (vid.line_req !== e.lr) || (vid.running !== 1'b1) ||
                  (e.de && ((vid.x !== 11'(e.x)) || (vid.y !== 10'(e.y)))) ||
                  (e.lr && (vid.line_req_y !== 10'(e.lry)));
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL %s p=%0d got hs=%b vs=%b de=%b x=%0d y=%0d fs=%b lr=%b lry=%0d run=%b expected hs=%b vs=%b de=%b x=%0d y=%0d fs=%b lr=%b lry=%0d run=1",
                         tag, pix, vid.hsync, vid.vsync, vid.de, vid.x, vid.y, vid.frame_start,
                         vid.line_req, vid.line_req_y, vid.running,
                         e.hs, e.vs, e.de, e.x, e.y, e.fs, e.lr, e.lry);
            end
            if (vid.de) de_cnt++;
            if (!vid.hsync) hs_cnt++;
            if (!vid.vsync) vs_cnt++;
            if (vid.line_req) lr_cnt++;
            if (vid.frame_start) begin
                if (fs_cnt > 0) fs_gaps.push_back(cyc - last_fs);
                last_fs = cyc;
                fs_cnt++;
            end
            tick();
            pix++;
        end
    endtask

    // Called right after lock (or reset release) becomes effective at the sampling point.
    task automatic expect_start(string tag);
        bit early = 1'b0;
        for (int unsigned i = 0; i < RUN_LAT - 1; i++) begin
            tick();
            if (vid.running !== 1'b0) early = 1'b1;
        end
        checks++;
        if (early) begin
            errors++;
            $display("FAIL %s_early running rose before %0d cycles", tag, RUN_LAT);
        end
        tick();
        checks++;
        if (vid.running !== 1'b1) begin
            errors++;
            $display("FAIL %s_running got %b expected 1 at %0d cycles", tag, vid.running, RUN_LAT);
        end
        checks++;
        if ({vid.frame_start, vid.de} !== 2'b00) begin
            errors++;
            $display("FAIL %s_pre_pixel got fs/de=%b%b expected 00", tag, vid.frame_start, vid.de);
        end
        tick();
        checks++;
        if ({vid.frame_start, vid.de, vid.x, vid.y} !== {1'b1, 1'b1, 11'd0, 10'd0}) begin
            errors++;
            $display("FAIL %s_first_pixel got fs=%b de=%b x=%0d y=%0d expected fs=1 de=1 x=0 y=0",
                     tag, vid.frame_start, vid.de, vid.x, vid.y);
        end
        pix = 0;
    endtask

    task automatic test_reset();
        bit ran = 1'b0;
        rst = 1'b1;
        locked = 1'b0;
        repeat (3) tick();
        checks++;
        if (outs() !== IDLE) begin
            errors++;
            $display("FAIL reset_values got %h expected %h", outs(), IDLE);
        end
        rst = 1'b0;
        for (int unsigned i = 0; i < 60; i++) begin
            tick();
            if (vid.running !== 1'b0) ran = 1'b1;
        end
        checks++;
        if (ran || outs() !== IDLE) begin
            errors++;
            $display("FAIL unlocked_idle got %h ran=%b expected %h ran=0", outs(), ran, IDLE);
        end
    endtask

    task automatic test_lock_to_run();
        locked = 1'b1;
        expect_start("lock");
        run_raster(3 * HT, "lock_run");
    endtask

    task automatic test_free_run();
        int unsigned prev;
        // resynchronise to a fresh frame so the 2-frame window starts at pixel (0,0)
        run_raster(FR - pix, "align");
        de_cnt = 0; hs_cnt = 0; vs_cnt = 0; lr_cnt = 0; fs_cnt = 0;
        fs_gaps.delete();
        run_raster(2 * FR + 1, "free");
        checks++;
        if (de_cnt !== 2 * HA * VA + 1) begin
            errors++;
            $display("FAIL de_total got %0d expected %0d", de_cnt, 2 * HA * VA + 1);
        end
        checks++;
        if (hs_cnt !== 2 * HS * VT) begin
            errors++;
            $display("FAIL hsync_low_total got %0d expected %0d", hs_cnt, 2 * HS * VT);
        end
        checks++;
        if (vs_cnt !== 2 * VS * HT) begin
            errors++;
            $display("FAIL vsync_low_total got %0d expected %0d", vs_cnt, 2 * VS * HT);
        end
        checks++;
        if (lr_cnt !== 2 * VA) begin
            errors++;
            $display("FAIL line_req_total got %0d expected %0d", lr_cnt, 2 * VA);
        end
        checks++;
        if (fs_gaps.size() !== 2) begin
            errors++;
            $display("FAIL frame_count got %0d gaps expected 2", fs_gaps.size());
        end
        foreach (fs_gaps[i]) begin
            prev = fs_gaps[i];
            checks++;
            if (prev !== FR) begin
                errors++;
                $display("FAIL frame_period got %0d expected %0d", prev, FR);
            end
        end
    endtask

    task automatic test_lock_loss();
        for (int unsigned it = 0; it < 3; it++) begin
            run_raster($urandom_range(FR / 4, FR), "pre_loss");
            locked = 1'b0;
            repeat (4) tick();
            checks++;
            if (outs() !== IDLE) begin
                errors++;
                $display("FAIL loss_idle got %h expected %h", outs(), IDLE);
            end
            repeat ($urandom_range(0, 15)) tick();
            locked = 1'b1;
            expect_start("relock");
            run_raster(2 * HT + $urandom_range(0, HT), "relock_run");
        end
    endtask

    task automatic test_glitch();
        int unsigned k;
        bit early = 1'b0;
        locked = 1'b0;
        repeat (5) tick();
        locked = 1'b1;
        k = $urandom_range(1, LW - 4);
        for (int unsigned i = 0; i < 3 + k; i++) begin
            tick();
            if (vid.running !== 1'b0) early = 1'b1;
        end
        checks++;
        if (early) begin
            errors++;
            $display("FAIL glitch_pre running rose before glitch (count %0d)", k);
        end
        locked = 1'b0;
        tick();
        locked = 1'b1;
        expect_start("glitch");
        run_raster(2 * HT, "glitch_run");
    endtask

    task automatic test_async_reset();
        run_raster((FR - pix) + $urandom_range(0, VA - 1) * HT + $urandom_range(1, HA - 2), "pre_rst");
        checks++;
        if (vid.de !== 1'b1) begin
            errors++;
            $display("FAIL pre_rst_active got de=%b expected 1", vid.de);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (outs() !== IDLE) begin
            errors++;
            $display("FAIL async_rst got %h expected %h", outs(), IDLE);
        end
        tick();
        tick();
        rst = 1'b0;
        expect_start("post_rst");
        run_raster(2 * HT, "post_rst_run");
    endtask

    initial begin
        rst = 1'b1;
        locked = 1'b0;
        test_reset();
        test_lock_to_run();
        test_free_run();
        test_lock_loss();
        test_glitch();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
